// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift engine: FSM state encoding and the
// helper that maps a bit position in the word onto a physical bit index.
package serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TX   = 2'd1;
  localparam logic [1:0] ST_RX   = 2'd2;

  // Position cnt in shift order -> physical bit index of the word.
  function automatic int unsigned idx(input int unsigned cnt,
                                      input int unsigned width,
                                      input bit          msb_first);
    return msb_first ? (width - 32'd1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/serial_shift_port_if.sv
// Word-side handshake and serial bus signals of the shift engine, bundled so
// the byte-level logic and the engine connect through one port.
interface serial_shift_port_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              rx_start;
  logic              abort;
  logic              bus_i;
  logic              bus_o;
  logic              bus_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic [CNT_W-1:0]  bit_cnt;

  modport master (
    output tx_data, tx_valid, rx_start, abort, bus_i,
    input  tx_ready, bus_o, bus_oe, rx_data, rx_valid, busy, bit_cnt
  );

  modport slave (
    input  tx_data, tx_valid, rx_start, abort, bus_i,
    output tx_ready, bus_o, bus_oe, rx_data, rx_valid, busy, bit_cnt
  );
endinterface

// File: rtl/serial_bit_counter.sv
// Bit position counter for one word: wraps from DATA_W-1 to 0, so values
// >= DATA_W never appear even when DATA_W is not a power of two.
module serial_bit_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DATA_W - 1);

  assign last = (cnt == LAST_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= last ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/serial_shift_port.sv
// Half-duplex serial shift engine: serialises or deserialises one DATA_W-bit
// word per transfer, one bit per clock, with registered bus_o/bus_oe.
module serial_shift_port
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_shift_port_if.slave sp
);

  localparam bit               MSB   = (MSB_FIRST != 0);
  localparam logic [CNT_W-1:0] FIRST = CNT_W'(idx(32'd0, DATA_W, MSB));

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              bus_o_q;
  logic              bus_oe_q;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic [CNT_W-1:0]  tx_sel;
  logic [CNT_W-1:0]  rx_sel;

  serial_bit_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state == ST_IDLE) || sp.abort),
    .en   (state != ST_IDLE),
    .cnt  (cnt),
    .last (last)
  );

  assign tx_sel = CNT_W'(idx(32'(cnt) + 32'd1, DATA_W, MSB));
  assign rx_sel = CNT_W'(idx(32'(cnt), DATA_W, MSB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Abort wins over word completion; abort in IDLE has no effect.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (sp.tx_valid)
          state_nxt = ST_TX;
        else if (sp.rx_start)
          state_nxt = ST_RX;
      end
      ST_TX: begin
        if (sp.abort || (last && !sp.tx_valid))
          state_nxt = ST_IDLE;
      end
      ST_RX: begin
        if (sp.abort || last)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sp.busy     = (state != ST_IDLE);
    sp.tx_ready = rst_n && ((state == ST_IDLE) || ((state == ST_TX) && last));
  end

  always_comb begin
    rx_word         = shreg;
    rx_word[rx_sel] = sp.bus_i;
  end

  // Datapath: the next bus bit is registered one cycle ahead of its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bus_o_q    <= 1'b0;
      bus_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sp.tx_valid) begin
            shreg    <= sp.tx_data;
            bus_o_q  <= sp.tx_data[FIRST];
            bus_oe_q <= 1'b1;
          end else if (sp.rx_start) begin
            shreg <= '0;
          end
        end
        ST_TX: begin
          if (sp.abort || (last && !sp.tx_valid)) begin
            bus_o_q  <= 1'b0;
            bus_oe_q <= 1'b0;
          end else if (last) begin
            shreg   <= sp.tx_data;
            bus_o_q <= sp.tx_data[FIRST];
          end else begin
            bus_o_q <= shreg[tx_sel];
          end
        end
        ST_RX: begin
          if (!sp.abort) begin
            shreg <= rx_word;
            if (last) begin
              rx_data_q  <= rx_word;
              rx_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          bus_o_q  <= 1'b0;
          bus_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign sp.bus_o    = bus_o_q;
  assign sp.bus_oe   = bus_oe_q;
  assign sp.rx_data  = rx_data_q;
  assign sp.rx_valid = rx_valid_q;
  assign sp.bit_cnt  = cnt;

endmodule

// File: tb/tb_serial_shift_port.sv
// Randomised bench for serial_shift_port: three instances (8-bit LSB-first,
// 8-bit MSB-first, 12-bit LSB-first) checked against a word-level model.
module tb_serial_shift_port;

  typedef struct {
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        rx_start;
    logic        abort;
    logic        bus_i;
  } drv_t;

  typedef struct {
    logic        bus_o;
    logic        bus_oe;
    logic        tx_ready;
    logic        busy;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic [3:0]  bit_cnt;
  } obs_t;

  logic        clk;
  logic        rst_n;
  drv_t        drv [3];
  logic [15:0] last_rx [3];
  logic        cap [$];
  int          checks;
  int          fails;

  serial_shift_port_if #(.DATA_W(8))  if0 ();
  serial_shift_port_if #(.DATA_W(8))  if1 ();
  serial_shift_port_if #(.DATA_W(12)) if2 ();

  serial_shift_port #(.DATA_W(8), .MSB_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .sp(if0));
  serial_shift_port #(.DATA_W(8), .MSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .sp(if1));
  serial_shift_port #(.DATA_W(12), .MSB_FIRST(0)) dut2 (.clk(clk), .rst_n(rst_n), .sp(if2));

  assign if0.tx_valid = drv[0].tx_valid;
  assign if0.tx_data  = drv[0].tx_data[7:0];
  assign if0.rx_start = drv[0].rx_start;
  assign if0.abort    = drv[0].abort;
  assign if0.bus_i    = drv[0].bus_i;
  assign if1.tx_valid = drv[1].tx_valid;
  assign if1.tx_data  = drv[1].tx_data[7:0];
  assign if1.rx_start = drv[1].rx_start;
  assign if1.abort    = drv[1].abort;
  assign if1.bus_i    = drv[1].bus_i;
  assign if2.tx_valid = drv[2].tx_valid;
  assign if2.tx_data  = drv[2].tx_data[11:0];
  assign if2.rx_start = drv[2].rx_start;
  assign if2.abort    = drv[2].abort;
  assign if2.bus_i    = drv[2].bus_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wOf(input int d);
    return (d == 2) ? 12 : 8;
  endfunction

  // i-th bit on the wire for word w, following each instance's bit order.
  function automatic logic expBit(input logic [15:0] w, input int i, input int d);
    int sh;
    sh = (d == 1) ? (wOf(d) - 1 - i) : i;
    return w[sh];
  endfunction

  function automatic logic [15:0] capFirstHigh();
    logic [15:0] v;
    v = '0;
    foreach (cap[i]) v = (v << 1) | 16'(cap[i]);
    return v;
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: begin
        o.bus_o = if0.bus_o; o.bus_oe = if0.bus_oe; o.tx_ready = if0.tx_ready;
        o.busy = if0.busy; o.rx_valid = if0.rx_valid;
        o.rx_data = 16'(if0.rx_data); o.bit_cnt = 4'(if0.bit_cnt);
      end
      1: begin
        o.bus_o = if1.bus_o; o.bus_oe = if1.bus_oe; o.tx_ready = if1.tx_ready;
        o.busy = if1.busy; o.rx_valid = if1.rx_valid;
        o.rx_data = 16'(if1.rx_data); o.bit_cnt = 4'(if1.bit_cnt);
      end
      default: begin
        o.bus_o = if2.bus_o; o.bus_oe = if2.bus_oe; o.tx_ready = if2.tx_ready;
        o.busy = if2.busy; o.rx_valid = if2.rx_valid;
        o.rx_data = 16'(if2.rx_data); o.bit_cnt = 4'(if2.bit_cnt);
      end
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic startTx(input int d, input logic [15:0] w);
    drv[d].tx_valid = 1'b1;
    drv[d].tx_data  = w;
  endtask

  // Follows one transmitted word bit by bit; optionally chains the next word or aborts.
  task automatic txWord(input int d, input logic [15:0] w, input bit chain,
                        input logic [15:0] nextw, input int abort_at);
    obs_t o;
    for (int i = 0; i < wOf(d); i++) begin
      @(negedge clk);
      o = observe(d);
      if (i == 0) begin
        drv[d].tx_valid = 1'b0;
        drv[d].tx_data  = 16'($urandom);
      end
      checkOutput($sformatf("tx%0d_oe_b%0d", d, i), o.bus_oe, 1);
      checkOutput($sformatf("tx%0d_bit_b%0d", d, i), o.bus_o, expBit(w, i, d));
      checkOutput($sformatf("tx%0d_rdy_b%0d", d, i), o.tx_ready, (i == wOf(d) - 1));
      checkOutput($sformatf("tx%0d_cnt_b%0d", d, i), o.bit_cnt, i);
      cap.push_back(o.bus_o);
      if (i == abort_at) begin
        drv[d].abort = 1'b1;
        @(negedge clk);
        drv[d].abort = 1'b0;
        o = observe(d);
        checkOutput($sformatf("tx%0d_abort_oe", d), o.bus_oe, 0);
        checkOutput($sformatf("tx%0d_abort_busy", d), o.busy, 0);
        checkOutput($sformatf("tx%0d_abort_cnt", d), o.bit_cnt, 0);
        return;
      end
      if ((i == wOf(d) - 1) && chain) begin
        drv[d].tx_valid = 1'b1;
        drv[d].tx_data  = nextw;
      end
    end
  endtask

  task automatic expectIdle(input int d);
    obs_t o;
    @(negedge clk);
    o = observe(d);
    checkOutput($sformatf("idle%0d_oe", d), o.bus_oe, 0);
    checkOutput($sformatf("idle%0d_busy", d), o.busy, 0);
    checkOutput($sformatf("idle%0d_rdy", d), o.tx_ready, 1);
  endtask

  // Receives word w from the bench-driven bus; abort_at >= 0 cuts it short.
  task automatic rxWord(input int d, input logic [15:0] w, input int abort_at);
    obs_t o;
    drv[d].rx_start = 1'b1;
    @(negedge clk);
    drv[d].rx_start = 1'b0;
    for (int i = 0; i < wOf(d); i++) begin
      o = observe(d);
      checkOutput($sformatf("rx%0d_oe_b%0d", d, i), o.bus_oe, 0);
      checkOutput($sformatf("rx%0d_busy_b%0d", d, i), o.busy, 1);
      checkOutput($sformatf("rx%0d_cnt_b%0d", d, i), o.bit_cnt, i);
      checkOutput($sformatf("rx%0d_vld_b%0d", d, i), o.rx_valid, 0);
      if (i == abort_at) begin
        drv[d].abort = 1'b1;
        @(negedge clk);
        drv[d].abort = 1'b0;
        o = observe(d);
        checkOutput($sformatf("rx%0d_abort_busy", d), o.busy, 0);
        checkOutput($sformatf("rx%0d_abort_vld", d), o.rx_valid, 0);
        checkOutput($sformatf("rx%0d_abort_data", d), o.rx_data, last_rx[d]);
        return;
      end
      drv[d].bus_i = expBit(w, i, d);
      @(negedge clk);
    end
    o = observe(d);
    checkOutput($sformatf("rx%0d_vld", d), o.rx_valid, 1);
    checkOutput($sformatf("rx%0d_data", d), o.rx_data, w);
    checkOutput($sformatf("rx%0d_done_busy", d), o.busy, 0);
    last_rx[d] = w;
    @(negedge clk);
    o = observe(d);
    checkOutput($sformatf("rx%0d_vld_pulse", d), o.rx_valid, 0);
    checkOutput($sformatf("rx%0d_data_hold", d), o.rx_data, w);
  endtask

  // One random transaction on an 8-bit instance.
  task automatic applyStimulus(input int op, input int d);
    logic [15:0] w;
    logic [15:0] w2;
    obs_t        o;
    w  = 16'($urandom_range(0, 255));
    w2 = 16'($urandom_range(0, 255));
    case (op)
      0: begin startTx(d, w); txWord(d, w, 1'b0, 16'h0, -1); expectIdle(d); end
      1: begin
        startTx(d, w);
        txWord(d, w, 1'b1, w2, -1);
        txWord(d, w2, 1'b0, 16'h0, -1);
        expectIdle(d);
      end
      2: rxWord(d, w, -1);
      3: rxWord(d, w, $urandom_range(0, 7));
      4: begin startTx(d, w); txWord(d, w, 1'b0, 16'h0, $urandom_range(0, 7)); end
      default: begin
        drv[d].abort = 1'b1;
        @(negedge clk);
        drv[d].abort = 1'b0;
        o = observe(d);
        checkOutput($sformatf("idle_abort%0d_busy", d), o.busy, 0);
        checkOutput($sformatf("idle_abort%0d_rdy", d), o.tx_ready, 1);
      end
    endcase
  endtask

  initial begin
    obs_t        o;
    logic [15:0] lb;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drv[d].tx_valid = 1'b0;
      drv[d].tx_data  = '0;
      drv[d].rx_start = 1'b0;
      drv[d].abort    = 1'b0;
      drv[d].bus_i    = 1'b0;
      last_rx[d]      = '0;
    end
    repeat (2) @(negedge clk);
    o = observe(0);
    checkOutput("rst_rdy", o.tx_ready, 0);
    checkOutput("rst_oe", o.bus_oe, 0);
    checkOutput("rst_bus_o", o.bus_o, 0);
    checkOutput("rst_busy", o.busy, 0);
    checkOutput("rst_cnt", o.bit_cnt, 0);
    checkOutput("rst_rx_data", o.rx_data, 0);
    checkOutput("rst_rx_vld", o.rx_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rdy", observe(0).tx_ready, 1);

    $display("[TB] LSB-first and MSB-first transmit");
    cap.delete();
    startTx(0, 16'hA5);
    txWord(0, 16'hA5, 1'b0, 16'h0, -1);
    expectIdle(0);
    checkOutput("lsb_a5_pattern", capFirstHigh(), 16'hA5);
    cap.delete();
    startTx(1, 16'hA5);
    txWord(1, 16'hA5, 1'b0, 16'h0, -1);
    expectIdle(1);
    checkOutput("msb_a5_pattern", capFirstHigh(), 16'hA5);
    cap.delete();
    startTx(1, 16'h01);
    txWord(1, 16'h01, 1'b0, 16'h0, -1);
    expectIdle(1);
    checkOutput("msb_01_pattern", capFirstHigh(), 16'h01);

    $display("[TB] back-to-back transmit");
    startTx(0, 16'hFF);
    txWord(0, 16'hFF, 1'b1, 16'h00, -1);
    txWord(0, 16'h00, 1'b0, 16'h0, -1);
    expectIdle(0);

    $display("[TB] receive, abort, receive");
    rxWord(0, 16'h3C, -1);
    rxWord(0, 16'h5E, 4);
    rxWord(0, 16'h81, -1);
    checkOutput("rx_after_abort", observe(0).rx_data, 16'h81);

    $display("[TB] async reset mid-transmit");
    startTx(0, 16'h3C);
    @(negedge clk);
    drv[0].tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_tx_cnt", observe(0).bit_cnt, 3);
    rst_n = 1'b0;
    #1;
    o = observe(0);
    checkOutput("async_rst_oe", o.bus_oe, 0);
    checkOutput("async_rst_busy", o.busy, 0);
    checkOutput("async_rst_rdy", o.tx_ready, 0);
    checkOutput("async_rst_cnt", o.bit_cnt, 0);
    checkOutput("async_rst_rx_data", o.rx_data, 0);
    for (int d = 0; d < 3; d++) last_rx[d] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startTx(0, 16'h5A);
    txWord(0, 16'h5A, 1'b0, 16'h0, -1);
    expectIdle(0);

    $display("[TB] 12-bit loopback");
    cap.delete();
    startTx(2, 16'hABC);
    txWord(2, 16'hABC, 1'b0, 16'h0, -1);
    expectIdle(2);
    lb = '0;
    foreach (cap[i]) lb = lb | (16'(cap[i]) << i);
    rxWord(2, lb, -1);
    checkOutput("loopback_12", observe(2).rx_data, 16'hABC);

    $display("[TB] random transactions");
    repeat (30) applyStimulus($urandom_range(0, 5), $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
